pong_ball_ctrl: RTL and testbench

- Game sequencer for the ball sprite and score state. Owns the ball position and velocity, and moves the ball once per video frame.
- Inputs: frame ticks from the VGA timing block, plus paddle-hit flags and hit zone from the hitbox checker.
- Outputs: a sprite_t ball record for the sprite renderer, signed velocity, scores and game state.
- Runs IDLE/SERVE/PLAY/POINT/OVER sequencing.

---
 rtl/sprite_pkg.sv | 62 ++++++
 rtl/pong_ball_step.sv | 83 ++++++++
 rtl/pong_ball_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pong_ball_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared sprite geometry and game constants for the pong ball sequencer.
package sprite_pkg;

  localparam int SCREEN_H_RES = 640;
  localparam int SCREEN_V_RES = 480;

  localparam int X_POS_W = 10;
  localparam int Y_POS_W = 9;

  // x position that parks a sprite just off the right edge of the screen
  localparam logic [X_POS_W-1:0] POS_HIDE = X_POS_W'(SCREEN_H_RES);

  typedef struct packed {
    logic [X_POS_W-1:0] x_pos;
    logic [Y_POS_W-1:0] y_pos;
    logic [X_POS_W-1:0] right;
    logic [Y_POS_W-1:0] bottom;
  } sprite_t;

  localparam int BALL_SIDE  = 10;
  localparam int BORDER     = 10;
  localparam int BALL_MIN_Y = BORDER;
  localparam int BALL_MAX_Y = SCREEN_V_RES - BORDER - BALL_SIDE;
  localparam int BALL_MAX_X = SCREEN_H_RES - BALL_SIDE;
  localparam int CENTRE_X   = SCREEN_H_RES / 2;
  localparam int CENTRE_Y   = SCREEN_V_RES / 2;

  localparam int SPEED_W      = 5;
  localparam int INIT_SPEED   = 4;
  localparam int DEFLECT_X    = 4;
  localparam int SIDE_Y       = 5;
  localparam int SERVE_FRAMES = 60;
  localparam int WIN_SCORE    = 9;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } game_state_t;

  // zone 3 is not produced by a well-behaved hitbox and is handled as middle
  typedef enum logic [1:0] {
    ZONE_TOP     = 2'd0,
    ZONE_MID     = 2'd1,
    ZONE_BOT     = 2'd2,
    ZONE_MID_ALT = 2'd3
  } hit_zone_t;

  // Builds the full sprite record from the top-left corner.
  function automatic sprite_t make_sprite(input logic [X_POS_W-1:0] x,
                                          input logic [Y_POS_W-1:0] y);
    sprite_t s;
    s.x_pos  = x;
    s.y_pos  = y;
    s.right  = x + X_POS_W'(BALL_SIDE - 1);
    s.bottom = y + Y_POS_W'(BALL_SIDE - 1);
    return s;
  endfunction

endpackage

// File: rtl/pong_ball_step.sv
// One-frame ball motion: paddle deflection, wall bounce and scoring flags.
// Purely combinational; the caller decides whether to commit the result.
module pong_ball_step
  import sprite_pkg::*;
(
  input  logic [X_POS_W-1:0]        x,
  input  logic [Y_POS_W-1:0]        y,
  input  logic signed [SPEED_W-1:0] vx,
  input  logic signed [SPEED_W-1:0] vy,
  input  logic                      hit_player,
  input  logic                      hit_enemy,
  input  hit_zone_t                 hit_zone,
  output logic [X_POS_W-1:0]        x_next,
  output logic [Y_POS_W-1:0]        y_next,
  output logic signed [SPEED_W-1:0] vx_next,
  output logic signed [SPEED_W-1:0] vy_next,
  output logic                      point_player,
  output logic                      point_enemy
);

  localparam logic signed [SPEED_W-1:0] V_DEFLECT = SPEED_W'(DEFLECT_X);
  localparam logic signed [SPEED_W-1:0] V_SIDE    = SPEED_W'(SIDE_Y);
  localparam logic signed [SPEED_W-1:0] V_ONE     = SPEED_W'(1);
  localparam logic signed [X_POS_W:0]   NX_MAX    = (X_POS_W+1)'(BALL_MAX_X);
  localparam logic signed [Y_POS_W:0]   NY_MIN    = (Y_POS_W+1)'(BALL_MIN_Y);
  localparam logic signed [Y_POS_W:0]   NY_MAX    = (Y_POS_W+1)'(BALL_MAX_Y);

  logic signed [X_POS_W:0]   nx;
  logic signed [Y_POS_W:0]   ny;
  logic                      deflect_p;
  logic                      deflect_e;
  logic signed [SPEED_W-1:0] vy_pad;
  logic signed [SPEED_W-1:0] vy_abs;

  // Candidate position one bit wider and signed so off-screen moves are visible;
  // a hit only counts when the paddle opposes the current horizontal motion.
  always_comb begin
    nx        = $signed({1'b0, x}) + (X_POS_W+1)'(vx);
    ny        = $signed({1'b0, y}) + (Y_POS_W+1)'(vy);
    deflect_p = hit_player && vx[SPEED_W-1];
    deflect_e = hit_enemy && !vx[SPEED_W-1] && (vx != '0);

    vy_pad = vy;
    if (deflect_p || deflect_e) begin
      case (hit_zone)
        ZONE_TOP: vy_pad = -V_SIDE;
        ZONE_BOT: vy_pad = V_SIDE;
        default:  vy_pad = vy[SPEED_W-1] ? -V_ONE : V_ONE;
      endcase
    end
    vy_abs = vy_pad[SPEED_W-1] ? -vy_pad : vy_pad;

    // Horizontal: deflect holds x for this frame, otherwise move or score.
    x_next       = x;
    vx_next      = vx;
    point_player = 1'b0;
    point_enemy  = 1'b0;
    if (deflect_p) begin
      vx_next = V_DEFLECT;
    end else if (deflect_e) begin
      vx_next = -V_DEFLECT;
    end else if (nx[X_POS_W]) begin
      point_enemy = 1'b1;
    end else if (nx > NX_MAX) begin
      point_player = 1'b1;
    end else begin
      x_next = nx[X_POS_W-1:0];
    end

    // Vertical: walls clamp and reflect using the post-paddle vy.
    if (ny <= NY_MIN) begin
      y_next  = Y_POS_W'(BALL_MIN_Y);
      vy_next = vy_abs;
    end else if (ny >= NY_MAX) begin
      y_next  = Y_POS_W'(BALL_MAX_Y);
      vy_next = -vy_abs;
    end else begin
      y_next  = ny[Y_POS_W-1:0];
      vy_next = vy_pad;
    end
  end

endmodule

// File: rtl/pong_ball_ctrl.sv
// Pong game sequencer: owns ball position/velocity and scores, stepping the
// ball once per frame tick through IDLE/SERVE/PLAY/POINT/OVER.
module pong_ball_ctrl
  import sprite_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      frame_tick_i,
  input  logic                      start_i,
  input  logic                      hit_player_i,
  input  logic                      hit_enemy_i,
  input  logic [1:0]                hit_zone_i,
  output sprite_t                   ball_o,
  output logic signed [SPEED_W-1:0] vx_o,
  output logic signed [SPEED_W-1:0] vy_o,
  output logic [3:0]                score_p_o,
  output logic [3:0]                score_e_o,
  output logic [2:0]                state_o,
  output logic                      game_over_o
);

  localparam int                        CNT_W      = $clog2(SERVE_FRAMES);
  localparam logic [CNT_W-1:0]          SERVE_LOAD = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [X_POS_W-1:0]        X_SERVE    = X_POS_W'(CENTRE_X);
  localparam logic [Y_POS_W-1:0]        Y_SERVE    = Y_POS_W'(CENTRE_Y);
  localparam logic signed [SPEED_W-1:0] V_SERVE    = SPEED_W'(INIT_SPEED);
  localparam logic signed [SPEED_W-1:0] V_ONE      = SPEED_W'(1);
  localparam logic [3:0]                SCORE_WIN  = 4'(WIN_SCORE);

  game_state_t               state;
  logic [X_POS_W-1:0]        x_q;
  logic [Y_POS_W-1:0]        y_q;
  logic signed [SPEED_W-1:0] vx_q;
  logic signed [SPEED_W-1:0] vy_q;
  logic [3:0]                score_p;
  logic [3:0]                score_e;
  // 1 = next serve goes right; also records who won the last rally
  logic                      serve_pos;
  logic [CNT_W-1:0]          count;

  logic [X_POS_W-1:0]        x_next;
  logic [Y_POS_W-1:0]        y_next;
  logic signed [SPEED_W-1:0] vx_next;
  logic signed [SPEED_W-1:0] vy_next;
  logic                      point_player;
  logic                      point_enemy;
  logic [3:0]                score_p_inc;
  logic [3:0]                score_e_inc;
  logic [3:0]                score_new;

  pong_ball_step u_step (
    .x            (x_q),
    .y            (y_q),
    .vx           (vx_q),
    .vy           (vy_q),
    .hit_player   (hit_player_i),
    .hit_enemy    (hit_enemy_i),
    .hit_zone     (hit_zone_t'(hit_zone_i)),
    .x_next       (x_next),
    .y_next       (y_next),
    .vx_next      (vx_next),
    .vy_next      (vy_next),
    .point_player (point_player),
    .point_enemy  (point_enemy)
  );

  // Saturating score increments; score_new is the winner's updated total.
  always_comb begin
    score_p_inc = (score_p == 4'hF) ? score_p : score_p + 4'd1;
    score_e_inc = (score_e == 4'hF) ? score_e : score_e + 4'd1;
    score_new   = serve_pos ? score_p_inc : score_e_inc;
  end

  // Game FSM; only start_i acts without a frame tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      x_q       <= POS_HIDE;
      y_q       <= Y_SERVE;
      vx_q      <= '0;
      vy_q      <= '0;
      score_p   <= '0;
      score_e   <= '0;
      serve_pos <= 1'b1;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            state <= SERVE;
            count <= SERVE_LOAD;
            x_q   <= X_SERVE;
            y_q   <= Y_SERVE;
          end
        end
        SERVE: begin
          if (frame_tick_i) begin
            if (count == '0) begin
              state <= PLAY;
              vx_q  <= serve_pos ? V_SERVE : -V_SERVE;
              vy_q  <= V_ONE;
            end else begin
              count <= count - 1'b1;
            end
          end
        end
        PLAY: begin
          if (frame_tick_i) begin
            if (point_player || point_enemy) begin
              state     <= POINT;
              serve_pos <= point_player;
              x_q       <= POS_HIDE;
              y_q       <= Y_SERVE;
              vx_q      <= '0;
              vy_q      <= '0;
            end else begin
              x_q  <= x_next;
              y_q  <= y_next;
              vx_q <= vx_next;
              vy_q <= vy_next;
            end
          end
        end
        POINT: begin
          if (frame_tick_i) begin
            if (serve_pos) score_p <= score_p_inc;
            else           score_e <= score_e_inc;
            if (score_new == SCORE_WIN) begin
              state <= OVER;
            end else begin
              state <= SERVE;
              count <= SERVE_LOAD;
              x_q   <= X_SERVE;
              y_q   <= Y_SERVE;
            end
          end
        end
        OVER: begin
          if (start_i) begin
            state     <= SERVE;
            score_p   <= '0;
            score_e   <= '0;
            serve_pos <= 1'b1;
            count     <= SERVE_LOAD;
            x_q       <= X_SERVE;
            y_q       <= Y_SERVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ball_o      = make_sprite(x_q, y_q);
  assign vx_o        = vx_q;
  assign vy_o        = vy_q;
  assign score_p_o   = score_p;
  assign score_e_o   = score_e;
  assign state_o     = state;
  assign game_over_o = (state == OVER);

endmodule

// File: tb/tb_pong_ball_ctrl.sv
// Bench for pong_ball_ctrl: integer game model checked every cycle, directed
// rallies with hand-computed positions, then randomized play.
module tb_pong_ball_ctrl;
  import sprite_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              frame_tick;
  logic              start;
  logic              hit_player;
  logic              hit_enemy;
  logic [1:0]        hit_zone;
  sprite_t           ball;
  logic signed [4:0] vx;
  logic signed [4:0] vy;
  logic [3:0]        score_p;
  logic [3:0]        score_e;
  logic [2:0]        state;
  logic              game_over;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 0;

  // game model: 0 idle, 1 serve, 2 play, 3 point, 4 over
  int m_state, m_x, m_y, m_vx, m_vy, m_sp, m_se, m_dir, m_cnt;

  pong_ball_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick_i (frame_tick),
    .start_i      (start),
    .hit_player_i (hit_player),
    .hit_enemy_i  (hit_enemy),
    .hit_zone_i   (hit_zone),
    .ball_o       (ball),
    .vx_o         (vx),
    .vy_o         (vy),
    .score_p_o    (score_p),
    .score_e_o    (score_e),
    .state_o      (state),
    .game_over_o  (game_over)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic model_reset();
    m_state = 0; m_x = 640; m_y = 240; m_vx = 0; m_vy = 0;
    m_sp = 0; m_se = 0; m_dir = 1; m_cnt = 0;
  endtask

  task automatic model_serve();
    m_state = 1; m_cnt = 59; m_x = 320; m_y = 240;
  endtask

  // One clock edge of the game rules, using the inputs the DUT saw.
  task automatic model_step();
    int nx, ny, nvy, won;
    bit defl;
    case (m_state)
      0: if (start) model_serve();
      1: if (frame_tick) begin
        if (m_cnt == 0) begin
          m_state = 2; m_vx = 4 * m_dir; m_vy = 1;
        end else m_cnt--;
      end
      2: if (frame_tick) begin
        nx   = m_x + m_vx;
        ny   = m_y + m_vy;
        nvy  = m_vy;
        defl = (hit_player && m_vx < 0) || (hit_enemy && m_vx > 0);
        if (defl) begin
          m_vx = (m_vx < 0) ? 4 : -4;
          if (hit_zone == 0)      nvy = -5;
          else if (hit_zone == 2) nvy = 5;
          else                    nvy = (m_vy < 0) ? -1 : 1;
        end
        if (!defl && (nx < 0 || nx > 630)) begin
          m_dir = (nx < 0) ? -1 : 1;
          m_state = 3; m_x = 640; m_y = 240; m_vx = 0; m_vy = 0;
        end else begin
          if (!defl) m_x = nx;
          if (ny <= 10)       begin m_y = 10;  m_vy = iabs(nvy);  end
          else if (ny >= 460) begin m_y = 460; m_vy = -iabs(nvy); end
          else                begin m_y = ny;  m_vy = nvy;        end
        end
      end
      3: if (frame_tick) begin
        if (m_dir > 0) begin if (m_sp < 15) m_sp++; won = m_sp; end
        else           begin if (m_se < 15) m_se++; won = m_se; end
        if (won == 9) m_state = 4;
        else          model_serve();
      end
      4: if (start) begin
        m_sp = 0; m_se = 0; m_dir = 1; model_serve();
      end
      default: ;
    endcase
  endtask

  // driver: apply inputs for one cycle, advance model at the edge, return at negedge
  task automatic drive(input bit t, input bit s, input bit hp, input bit he, input int z);
    frame_tick = t; start = s; hit_player = hp; hit_enemy = he; hit_zone = 2'(z);
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) drive(1, 0, 0, 0, 0);
  endtask

  // scoreboard compare: every output against the model, once per cycle
  always @(negedge clk) begin
    if (check_en) begin
      check("state", int'(state), m_state);
      check("x_pos", int'(ball.x_pos), m_x);
      check("y_pos", int'(ball.y_pos), m_y);
      check("right", int'(ball.right), m_x + 9);
      check("bottom", int'(ball.bottom), m_y + 9);
      check("vx", int'(vx), m_vx);
      check("vy", int'(vy), m_vy);
      check("score_p", int'(score_p), m_sp);
      check("score_e", int'(score_e), m_se);
      check("game_over", int'(game_over), (m_state == 4) ? 1 : 0);
    end
  end

  initial begin
    rst_n = 1'b0; frame_tick = 0; start = 0; hit_player = 0; hit_enemy = 0; hit_zone = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check("rst_state", int'(state), 0);
    check("rst_x", int'(ball.x_pos), 640);
    check("rst_y", int'(ball.y_pos), 240);
    check("rst_vx", int'(vx), 0);
    check("rst_game_over", int'(game_over), 0);
    rst_n = 1'b1;
    check_en = 1;

    // start and serve
    drive(0, 1, 0, 0, 0);
    check("serve_state", int'(state), 1);
    check("serve_x", int'(ball.x_pos), 320);
    check("serve_y", int'(ball.y_pos), 240);
    ticks(59);
    check("serve_wait_state", int'(state), 1);
    ticks(1);
    check("play_state", int'(state), 2);
    check("play_vx", int'(vx), 4);
    check("play_vy", int'(vy), 1);
    ticks(1);
    check("first_move_x", int'(ball.x_pos), 324);
    check("first_move_y", int'(ball.y_pos), 241);

    // enemy paddle, top zone: deflect with x held; repeat hit is ignored
    drive(1, 0, 0, 1, 0);
    check("deflect_x", int'(ball.x_pos), 324);
    check("deflect_vx", int'(vx), -4);
    check("deflect_vy", int'(vy), -5);
    drive(1, 0, 0, 1, 0);
    check("ignored_hit_x", int'(ball.x_pos), 320);
    check("ignored_hit_vx", int'(vx), -4);

    // top wall
    ticks(45);
    check("pre_top_y", int'(ball.y_pos), 12);
    ticks(1);
    check("top_wall_y", int'(ball.y_pos), 10);
    check("top_wall_vy", int'(vy), 5);
    check("top_wall_x", int'(ball.x_pos), 136);

    // ball leaves on the left: enemy point, then serve leftwards
    ticks(35);
    check("point_state", int'(state), 3);
    ticks(1);
    check("enemy_score", int'(score_e), 1);
    check("after_point_state", int'(state), 1);
    ticks(60);
    check("serve_left_vx", int'(vx), -4);

    // player paddle, bottom zone, then bottom wall
    drive(1, 0, 1, 0, 2);
    check("bot_deflect_vx", int'(vx), 4);
    check("bot_deflect_vy", int'(vy), 5);
    check("bot_deflect_x", int'(ball.x_pos), 320);
    ticks(43);
    check("pre_bottom_y", int'(ball.y_pos), 456);
    ticks(1);
    check("bottom_wall_y", int'(ball.y_pos), 460);
    check("bottom_wall_vy", int'(vy), -5);

    // let the player win the game
    for (int i = 0; i < 4000 && game_over !== 1'b1; i++) ticks(1);
    check("over_wait", int'(game_over), 1);
    check("over_score_p", int'(score_p), 9);
    check("over_score_e", int'(score_e), 1);
    check("over_x", int'(ball.x_pos), 640);
    check("over_y", int'(ball.y_pos), 240);
    check("over_state", int'(state), 4);
    drive(0, 1, 0, 0, 0);
    check("restart_state", int'(state), 1);
    check("restart_score_p", int'(score_p), 0);
    check("restart_x", int'(ball.x_pos), 320);

    // randomized play
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 1) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
            int'($urandom_range(0, 3)));
    end

    // reach PLAY, then pull reset between clock edges
    for (int i = 0; i < 300 && state !== 3'd2; i++) drive(1, 1, 0, 0, 0);
    check("play_wait", int'(state), 2);
    ticks(3);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_state", int'(state), 0);
    check("async_rst_x", int'(ball.x_pos), 640);
    check("async_rst_y", int'(ball.y_pos), 240);
    check("async_rst_vx", int'(vx), 0);
    check("async_rst_vy", int'(vy), 0);
    check("async_rst_score_p", int'(score_p), 0);
    check("async_rst_score_e", int'(score_e), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0);

    check_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
